// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies a synchronized lock, then releases
// rst_core and rst_periph in order. Optional lock-loss counter: PLL_RESET_SEQ_LOCK_LOSS_CNT_EN.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_HOLD      = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int RELEASE_GAP    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int PW     = ($clog2(PLL_RST_CYCLES) < 1) ? 1 : $clog2(PLL_RST_CYCLES);
  localparam int GW     = ($clog2(RELEASE_GAP) < 1) ? 1 : $clog2(RELEASE_GAP);
  localparam int TMW    = (PW > GW) ? PW : GW;
  localparam int HW     = ($clog2(LOCK_HOLD) < 1) ? 1 : $clog2(LOCK_HOLD);
  localparam int TOW    = ($clog2(LOCK_TIMEOUT) < 1) ? 1 : $clog2(LOCK_TIMEOUT);

  localparam logic [TMW-1:0] PLL_LAST  = TMW'(PLL_RST_CYCLES - 1);
  localparam logic [TMW-1:0] GAP_LAST  = TMW'(RELEASE_GAP - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LOCK_HOLD - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_t;

  state_t          state, state_n;
  logic [SYNC_N-1:0] sync_q;
  logic            lock_s;
  logic [TMW-1:0]  timer, timer_n;
  logic [HW-1:0]   hold, hold_n;
  logic [TOW-1:0]  to_cnt, to_n;
  logic [3:0]      retry_n;
  logic            loss_evt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_N-2:0], locked};
  end

  assign lock_s = sync_q[SYNC_N-1];

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    hold_n   = hold;
    to_n     = to_cnt;
    retry_n  = retry_cnt;
    loss_evt = 1'b0;
    case (state)
      RESET_PLL: begin
        hold_n = '0;
        to_n   = '0;
        if (timer == PLL_LAST) begin
          state_n = WAIT_LOCK;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WAIT_LOCK: begin
        timer_n = '0;
        hold_n  = lock_s ? hold + 1'b1 : '0;
        to_n    = to_cnt + 1'b1;
        // Hold completion is tested first so it wins over a coincident timeout.
        if (lock_s && hold == HOLD_LAST) begin
          state_n = RELEASE;
          hold_n  = '0;
          to_n    = '0;
        end else if (to_cnt == TO_LAST) begin
          state_n = RESET_PLL;
          hold_n  = '0;
          to_n    = '0;
          if (retry_cnt != 4'd15) retry_n = retry_cnt + 4'd1;
        end
      end
      RELEASE: begin
        hold_n = '0;
        to_n   = '0;
        if (!lock_s) begin
          state_n  = WAIT_LOCK;
          timer_n  = '0;
          loss_evt = 1'b1;
        end else if (timer == GAP_LAST) begin
          state_n = RUN;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      RUN: begin
        hold_n  = '0;
        to_n    = '0;
        timer_n = '0;
        if (!lock_s) begin
          state_n  = WAIT_LOCK;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_n = RESET_PLL;
        timer_n = '0;
        hold_n  = '0;
        to_n    = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_PLL;
      timer      <= '0;
      hold       <= '0;
      to_cnt     <= '0;
      retry_cnt  <= 4'd0;
      pll_rst    <= 1'b1;
      rst_core   <= 1'b1;
      rst_periph <= 1'b1;
      ready      <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      hold       <= hold_n;
      to_cnt     <= to_n;
      retry_cnt  <= retry_n;
      pll_rst    <= (state_n == RESET_PLL);
      rst_core   <= !(state_n == RELEASE || state_n == RUN);
      rst_periph <= (state_n != RUN);
      ready      <= (state_n == RUN);
    end
  end

`ifdef PLL_RESET_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             loss_q <= 8'd0;
    else if (loss_evt && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
  end

  assign lock_loss_cnt = loss_q;
`else
  logic unused_loss_evt;

  assign unused_loss_evt = loss_evt;
  assign lock_loss_cnt   = 8'd0;
`endif

endmodule
